load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Initiator side of the data-memory port. Accepts one load/store request per transaction from the pipeline.
//  Drives Mem_Addr/Write_Data/MemRead/MemWrite into the 64-bit little-endian, byte-addressed data memory.
//  Returns extended load data, or a store ack, on a valid/ready response channel.
//  Handles sub-doubleword stores by read-modify-write, because the memory always writes 8 bytes.
// PARAMETERS
//  MEM_BYTES  64  data-memory size in bytes; legal access iff addr <= MEM_BYTES-8
// PORTS
//  clk           in   1   clock; all state changes on posedge
//  reset_n       in   1   asynchronous, active-low reset
//  req_valid     in   1   request present
//  req_ready     out  1   unit can accept a request (high only in IDLE)
//  req_is_store  in   1   1=store, 0=load
//  req_funct3    in   3   RISC-V funct3: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu
//  req_addr      in   64  byte address
//  req_wdata     in   64  store data; low bytes used per size
//  resp_valid    out  1   response present; held until resp_ready
//  resp_ready    in   1   consumer accepts response
//  resp_rdata    out  64  load result, sign- or zero-extended; 0 for stores and errors
//  resp_err      out  1   illegal funct3 or out-of-range address
//  Mem_Addr      out  64  memory byte address
//  Write_Data    out  64  memory write data
//  MemRead       out  1   memory read enable; Read_Data is combinational in the same cycle
//  MemWrite      out  1   memory write enable; memory writes 8 bytes at the next posedge
//  Read_Data     in   64  memory read data
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata, Mem_Addr, Write_Data=0; MemRead=MemWrite=0.
//  Reset acts immediately. A store aborted before its WRITE edge never writes memory.
//  States: IDLE, READ, WRITE, RESP. Request fields are latched on req_valid & req_ready.
//  Accept -> next state:
//   - error -> RESP
//   - load -> READ
//   - sd -> WRITE
//   - sb/sh/sw -> READ
//  Error cases, evaluated at accept; no memory access occurs, resp_err=1, resp_rdata=0:
//   - req_addr > MEM_BYTES-8 (64-bit unsigned compare)
//   - funct3=111
//   - store with funct3[2]=1
//  READ (1 cycle): MemRead=1, Mem_Addr=addr; capture Read_Data at posedge.
//   - load: extend the low 8/16/32/64 bits per funct3 (bit2=1 -> zero-extend), then -> RESP.
//   - store: merge the low 1/2/4 bytes of wdata over captured data, then -> WRITE.
//  WRITE (1 cycle): MemWrite=1, Mem_Addr=addr, Write_Data=merged or full data, then -> RESP.
//  RESP: resp_valid=1, outputs stable until resp_ready; on handshake -> IDLE (req_ready=1 next cycle).
//  MemRead/MemWrite low in every other state; never both high.
//  Latency, accept edge to resp_valid:
//   - load: 2 cycles
//   - sd: 2 cycles
//   - sb/sh/sw: 3 cycles
//   - error: 1 cycle
//  No pipelining; one transaction in flight. Requests in non-IDLE states are ignored.
//  Back-to-back: resp_ready held high lets a new accept occur the cycle after the response handshake.
// TESTING
//  Memory init: bytes 0-7 = {10,0,...}, bytes 8-31 = own index, bytes 32-41 = 0..9, rest 0.
//  1. ld @8 -> resp_rdata=0x0F0E0D0C0B0A0908, err=0. lb @8 -> 0x08. ld @0 -> 0x0A. 2-cycle latency each.
//  2. sb 0x80 @16, then lb @16 -> 0xFFFFFFFFFFFFFF80; lbu @16 -> 0x80; ld @16 -> 0x1716151413121180.
//  3. sh 0xBEEF @32, then ld @32 -> 0x070605040302BEEF (RMW preserves bytes 34-39; MemRead 1 cycle then MemWrite 1 cycle).
//  4. ld @57 and funct3=111 -> resp_err=1, rdata=0, MemRead/MemWrite never asserted, resp after 1 cycle.
//  5. resp_ready=0 for 5 cycles after a lw @8 -> resp_valid/rdata=0x0B0A0908 held, req_ready=0 throughout.
//  6. reset_n low during READ of sw @24 -> all outputs reset immediately; later ld @24 returns the original 0x1F1E1D1C1B1A1918.

Source files
------------

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Initiator side of a 64-bit little-endian, byte-addressed data-memory port.
// Takes one load/store request at a time, returns extended load data or a
// store acknowledge on a valid/ready response channel. Sub-doubleword stores
// are done as read-modify-write because the memory always writes 8 bytes.
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   req_valid/req_ready           request handshake (ready only when idle)
//   req_is_store, req_funct3      access kind and RISC-V size/sign encoding
//   req_addr, req_wdata           byte address and store data
//   resp_valid/resp_ready         response handshake
//   resp_rdata, resp_err          extended load data (0 for stores/errors), error
//   Mem_Addr, Write_Data          memory address and write data
//   MemRead, MemWrite             memory enables (never both high)
//   Read_Data                     memory read data (combinational)
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int MEM_BYTES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic [63:0] Mem_Addr,
    output logic [63:0] Write_Data,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [63:0] Read_Data
);

    localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;     // store data, later the merged doubleword
    logic [2:0]  funct3_q, funct3_d;
    logic        is_store_q, is_store_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [63:0] mem_addr_q, mem_addr_d;
    logic [63:0] write_data_q, write_data_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        illegal_s;

    // Sign- or zero-extend the low 1/2/4/8 bytes; funct3[2] selects zero-extension.
    function automatic logic [63:0] extend_load(input logic [63:0] raw, input logic [2:0] f3);
        logic [63:0] res;
        case (f3[1:0])
            2'b00:   res = f3[2] ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
            2'b01:   res = f3[2] ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            2'b10:   res = f3[2] ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    // Overlay the low 1/2/4 bytes of the store data onto the doubleword read back.
    function automatic logic [63:0] merge_store(input logic [63:0] old_d, input logic [63:0] new_d,
                                                input logic [1:0] sz);
        logic [63:0] res;
        case (sz)
            2'b00:   res = {old_d[63:8],  new_d[7:0]};
            2'b01:   res = {old_d[63:16], new_d[15:0]};
            2'b10:   res = {old_d[63:32], new_d[31:0]};
            default: res = new_d;
        endcase
        return res;
    endfunction

    // Request legality, judged on the live request fields at accept time.
    always_comb begin
        illegal_s = (req_addr > MAX_ADDR) || (req_funct3 == 3'b111) ||
                    (req_is_store && req_funct3[2]);
    end

    // Next-state, datapath and next memory-port values.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        funct3_d   = funct3_q;
        is_store_d = is_store_q;
        rdata_d    = rdata_q;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    funct3_d   = req_funct3;
                    is_store_d = req_is_store;
                    rdata_d    = 64'd0;
                    err_d      = illegal_s;
                    if (illegal_s) begin
                        state_d = ST_RESP;
                    end else if (req_is_store && (req_funct3[1:0] == 2'b11)) begin
                        state_d = ST_WRITE;   // full doubleword, no read needed
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (is_store_q) begin
                    wdata_d = merge_store(Read_Data, wdata_q, funct3_q[1:0]);
                    state_d = ST_WRITE;
                end else begin
                    rdata_d = extend_load(Read_Data, funct3_q);
                    state_d = ST_RESP;
                end
            end
            ST_WRITE: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Memory port is registered: drive it for the state being entered.
        mem_read_d   = (state_d == ST_READ);
        mem_write_d  = (state_d == ST_WRITE);
        mem_addr_d   = (mem_read_d || mem_write_d) ? addr_d : 64'd0;
        write_data_d = mem_write_d ? wdata_d : 64'd0;
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= 64'd0;
            wdata_q      <= 64'd0;
            funct3_q     <= 3'd0;
            is_store_q   <= 1'b0;
            rdata_q      <= 64'd0;
            err_q        <= 1'b0;
            mem_addr_q   <= 64'd0;
            write_data_q <= 64'd0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            funct3_q     <= funct3_d;
            is_store_q   <= is_store_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            mem_addr_q   <= mem_addr_d;
            write_data_q <= write_data_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign Mem_Addr   = mem_addr_q;
    assign Write_Data = write_data_q;
    assign MemRead    = mem_read_q;
    assign MemWrite   = mem_write_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a byte-array data memory, a directed vector table,
// hold/reset sequences, and random transactions against a byte-level model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [63:0] Mem_Addr;
    logic [63:0] Write_Data;
    logic        MemRead;
    logic        MemWrite;
    logic [63:0] Read_Data;

    int n_tests = 0;
    int n_fail  = 0;

    load_store_unit #(.MEM_BYTES(64)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_store(req_is_store), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .Mem_Addr(Mem_Addr), .Write_Data(Write_Data),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .Read_Data(Read_Data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input int i);
        if (i == 0) return 8'd10;
        if (i >= 8 && i <= 31) return 8'(i);
        if (i >= 32 && i <= 41) return 8'(i - 32);
        return 8'd0;
    endfunction

    // Data memory seen by the DUT.
    logic [7:0] mem [0:63];
    bit mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_byte(i);
            mem_loaded <= 1'b1;
        end else if (MemWrite && Mem_Addr <= 64'd56) begin
            for (int k = 0; k < 8; k++) mem[int'(Mem_Addr[5:0]) + k] <= Write_Data[8*k +: 8];
        end
    end

    always_comb begin
        Read_Data = 64'd0;
        if (MemRead && Mem_Addr <= 64'd56) begin
            for (int k = 0; k < 8; k++) Read_Data[8*k +: 8] = mem[int'(Mem_Addr[5:0]) + k];
        end
    end

    // Free-running memory-enable cycle counters.
    int n_reads = 0, n_writes = 0, n_both = 0;
    always @(posedge clk) begin
        if (MemRead) n_reads++;
        if (MemWrite) n_writes++;
        if (MemRead && MemWrite) n_both++;
    end

    // Reference model: its own byte image of memory.
    logic [7:0] ref_mem [0:63];

    task automatic ref_txn(input logic st, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] wd, output logic [63:0] rd, output logic er,
                           output int lat, output int rds, output int wrs);
        int size;
        logic [63:0] val;
        size = 1 << f3[1:0];
        er = (addr > 64'd56) || (f3 == 3'b111) || (st && f3[2]);
        rd = 64'd0;
        if (er) begin
            lat = 1; rds = 0; wrs = 0;
        end else if (!st) begin
            val = 64'd0;
            for (int i = 0; i < size; i++) val = val | (64'(ref_mem[int'(addr) + i]) << (8 * i));
            if (!f3[2] && size < 8 && val[8*size-1]) val = val | ~((64'd1 << (8 * size)) - 64'd1);
            rd = val;
            lat = 2; rds = 1; wrs = 0;
        end else begin
            for (int i = 0; i < size; i++) ref_mem[int'(addr) + i] = wd[8*i +: 8];
            lat = (size == 8) ? 2 : 3;
            rds = (size == 8) ? 0 : 1;
            wrs = 1;
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One complete transaction with resp_ready held high.
    task automatic run_txn(input logic st, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] wd, output logic [63:0] rd, output logic er,
                           output int lat, output int rds, output int wrs, output int both);
        int r0, w0, b0;
        @(negedge clk);
        r0 = n_reads; w0 = n_writes; b0 = n_both;
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
        req_addr = addr; req_wdata = wd; resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!resp_valid) chk("resp_timeout", 64'd0, 64'd1);
        rd = resp_rdata; er = resp_err;
        @(posedge clk); #1;
        chk("req_ready_after_resp", 64'(req_ready), 64'd1);
        rds = n_reads - r0; wrs = n_writes - w0; both = n_both - b0;
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic        err;
        int          lat;
        int          rds;
        int          wrs;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [63:0] a,
                                input logic [63:0] wd, input logic [63:0] rd, input logic er,
                                input int lat, input int rds, input int wrs);
        vec_t v;
        v.st = st; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rd; v.err = er;
        v.lat = lat; v.rds = rds; v.wrs = wrs;
        return v;
    endfunction

    initial begin
        vec_t tbl[$];
        logic [63:0] rd, erd;
        logic er, eer;
        int lat, rds, wrs, both, elat, erds, ewrs;
        logic st;
        logic [2:0] f3;
        logic [63:0] addr, wd;

        for (int i = 0; i < 64; i++) ref_mem[i] = init_byte(i);

        tbl.push_back(mk(0, 3'd3, 64'd8,  64'd0, 64'h0F0E0D0C0B0A0908, 0, 2, 1, 0));
        tbl.push_back(mk(0, 3'd0, 64'd8,  64'd0, 64'h08, 0, 2, 1, 0));
        tbl.push_back(mk(0, 3'd3, 64'd0,  64'd0, 64'h0A, 0, 2, 1, 0));
        tbl.push_back(mk(1, 3'd0, 64'd16, 64'h80, 64'd0, 0, 3, 1, 1));
        tbl.push_back(mk(0, 3'd0, 64'd16, 64'd0, 64'hFFFFFFFFFFFFFF80, 0, 2, 1, 0));
        tbl.push_back(mk(0, 3'd4, 64'd16, 64'd0, 64'h80, 0, 2, 1, 0));
        tbl.push_back(mk(0, 3'd3, 64'd16, 64'd0, 64'h1716151413121180, 0, 2, 1, 0));
        tbl.push_back(mk(1, 3'd1, 64'd32, 64'hBEEF, 64'd0, 0, 3, 1, 1));
        tbl.push_back(mk(0, 3'd3, 64'd32, 64'd0, 64'h070605040302BEEF, 0, 2, 1, 0));
        tbl.push_back(mk(0, 3'd3, 64'd57, 64'd0, 64'd0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 3'd7, 64'd0,  64'd0, 64'd0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 3'd4, 64'd0,  64'hFF, 64'd0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 3'd3, 64'hFFFFFFFFFFFFFFF8, 64'd0, 64'd0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 3'd3, 64'd56, 64'h1122334455667788, 64'd0, 0, 2, 0, 1));
        tbl.push_back(mk(0, 3'd3, 64'd56, 64'd0, 64'h1122334455667788, 0, 2, 1, 0));
        tbl.push_back(mk(0, 3'd2, 64'd56, 64'd0, 64'h55667788, 0, 2, 1, 0));
        tbl.push_back(mk(0, 3'd0, 64'd56, 64'd0, 64'hFFFFFFFFFFFFFF88, 0, 2, 1, 0));
        tbl.push_back(mk(0, 3'd2, 64'd60, 64'd0, 64'd0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 3'd5, 64'd8,  64'd0, 64'h0908, 0, 2, 1, 0));
        tbl.push_back(mk(0, 3'd6, 64'd8,  64'd0, 64'h0B0A0908, 0, 2, 1, 0));
        tbl.push_back(mk(1, 3'd2, 64'd44, 64'h123456789ABCDEF0, 64'd0, 0, 3, 1, 1));
        tbl.push_back(mk(0, 3'd2, 64'd44, 64'd0, 64'hFFFFFFFF9ABCDEF0, 0, 2, 1, 0));
        tbl.push_back(mk(0, 3'd6, 64'd44, 64'd0, 64'h9ABCDEF0, 0, 2, 1, 0));
        tbl.push_back(mk(0, 3'd1, 64'd44, 64'd0, 64'hFFFFFFFFFFFFDEF0, 0, 2, 1, 0));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", 64'(req_ready), 64'd1);
        chk("reset_resp", {61'd0, resp_valid, resp_err, 1'b0} | resp_rdata, 64'd0);
        chk("reset_mem_port", Mem_Addr | Write_Data | 64'(MemRead) | 64'(MemWrite), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed table; the model tracks stores so later random checks stay in sync.
        for (int i = 0; i < tbl.size(); i++) begin
            ref_txn(tbl[i].st, tbl[i].f3, tbl[i].addr, tbl[i].wdata, erd, eer, elat, erds, ewrs);
            run_txn(tbl[i].st, tbl[i].f3, tbl[i].addr, tbl[i].wdata, rd, er, lat, rds, wrs, both);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rdata);
            chk($sformatf("vec%0d_err", i), 64'(er), 64'(tbl[i].err));
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(tbl[i].lat));
            chk($sformatf("vec%0d_reads", i), 64'(rds), 64'(tbl[i].rds));
            chk($sformatf("vec%0d_writes", i), 64'(wrs), 64'(tbl[i].wrs));
            chk($sformatf("vec%0d_both_enables", i), 64'(both), 64'd0);
        end

        // Response held while resp_ready is low.
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'd2; req_addr = 64'd8;
        resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("hold_latency", 64'(lat), 64'd2);
        for (int c = 0; c < 5; c++) begin
            req_valid = 1'b1;   // must be ignored outside idle
            @(posedge clk); #1;
            chk($sformatf("hold%0d_valid", c), 64'(resp_valid), 64'd1);
            chk($sformatf("hold%0d_rdata", c), resp_rdata, 64'h0B0A0908);
            chk($sformatf("hold%0d_req_ready", c), 64'(req_ready), 64'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("hold_release_req_ready", 64'(req_ready), 64'd1);

        // Reset during the read phase of a sub-word store.
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'd2;
        req_addr = 64'd24; req_wdata = 64'hDEADBEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("abort_in_read", 64'(MemRead), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_req_ready", 64'(req_ready), 64'd1);
        chk("abort_resp", {62'd0, resp_valid, resp_err} | resp_rdata, 64'd0);
        chk("abort_mem_port", Mem_Addr | Write_Data | 64'(MemRead) | 64'(MemWrite), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        run_txn(1'b0, 3'd3, 64'd24, 64'd0, rd, er, lat, rds, wrs, both);
        chk("abort_ld24", rd, 64'h1F1E1D1C1B1A1918);

        // Random transactions against the model.
        for (int i = 0; i < 300; i++) begin
            int sel;
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 9);
            if (sel < 8)       addr = 64'($urandom_range(0, 56));
            else if (sel == 8) addr = 64'($urandom_range(57, 70));
            else               addr = {32'($urandom), 32'($urandom)};
            wd = {32'($urandom), 32'($urandom)};
            ref_txn(st, f3, addr, wd, erd, eer, elat, erds, ewrs);
            run_txn(st, f3, addr, wd, rd, er, lat, rds, wrs, both);
            chk($sformatf("rnd%0d_rdata", i), rd, erd);
            chk($sformatf("rnd%0d_err", i), 64'(er), 64'(eer));
            chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'(elat));
            chk($sformatf("rnd%0d_mem", i), {32'(rds), 16'(wrs), 16'(both)},
                {32'(erds), 16'(ewrs), 16'd0});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
